// File: rtl/tagged_regfile_ckpt_pkg.sv
// Shared widths, CDB field layout and CDB snoop helper for the tagged register file.
package tagged_regfile_ckpt_pkg;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 8;
  localparam int NUM_RD   = 2;
  localparam int NUM_CDB  = 2;
  localparam int NUM_CKPT = 4;

  localparam int ADDR_W  = $clog2(NUM_REGS);
  localparam int CKPT_W  = $clog2(NUM_CKPT);
  localparam int ENTRY_W = TAG_W + DATA_W;

  // One CDB lane is {on, tag, data}, data in the low bits.
  localparam int CDB_DATA_LSB = 0;
  localparam int CDB_TAG_LSB  = DATA_W;
  localparam int CDB_ON_BIT   = DATA_W + TAG_W;
  localparam int CDB_W        = 1 + TAG_W + DATA_W;

  typedef logic [NUM_CDB*CDB_W-1:0] cdb_bus_t;

  // True when some active CDB broadcasts tag t; tag 0 means "ready" and never matches.
  function automatic logic cdb_hit(input cdb_bus_t bus, input logic [TAG_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (bus[k*CDB_W + CDB_ON_BIT] &&
          (bus[k*CDB_W + CDB_TAG_LSB +: TAG_W] == t) && (t != '0))
        hit = 1'b1;
    end
    return hit;
  endfunction
endpackage

// File: rtl/tagged_regfile_ckpt_alloc.sv
// Checkpoint slot allocator: free mask, lowest-free grant, release and restore/kill frees.
module tagged_regfile_ckpt_alloc
  import tagged_regfile_ckpt_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                take,
  input  logic                rel,
  input  logic [CKPT_W-1:0]   rel_id,
  input  logic                restore,
  input  logic [CKPT_W-1:0]   restore_id,
  input  logic [NUM_CKPT-1:0] kill,
  output logic                ack,
  output logic [CKPT_W-1:0]   id,
  output logic                full,
  output logic [NUM_CKPT-1:0] free
);
  logic [NUM_CKPT-1:0] free_q;
  logic [NUM_CKPT-1:0] free_nxt;
  logic                found;

  // Grant the lowest free slot from the current mask, so a slot released this
  // cycle cannot be handed out until the next one.
  always_comb begin
    found = 1'b0;
    id    = '0;
    for (int s = 0; s < NUM_CKPT; s++) begin
      if (free_q[s] && !found) begin
        id    = CKPT_W'(s);
        found = 1'b1;
      end
    end
    ack = rst_n && take && !restore && found;
  end

  // Frees first, then clear the granted slot.
  always_comb begin
    free_nxt = free_q;
    if (rel) free_nxt[rel_id] = 1'b1;
    if (restore) begin
      free_nxt             = free_nxt | kill;
      free_nxt[restore_id] = 1'b1;
    end
    for (int s = 0; s < NUM_CKPT; s++) begin
      if (ack && (id == CKPT_W'(s))) free_nxt[s] = 1'b0;
    end
  end

  // Free mask register; all slots free out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) free_q <= '1;
    else        free_q <= free_nxt;
  end

  assign full = ~|free_q;
  assign free = free_q;
endmodule

// File: rtl/tagged_regfile_ckpt.sv
// Tagged architectural register file with CDB snooping and internal tag checkpoints.
module tagged_regfile_ckpt
  import tagged_regfile_ckpt_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD*ENTRY_W-1:0] rd_data,
  input  logic                      ren_we,
  input  logic [ADDR_W-1:0]         ren_addr,
  input  logic [TAG_W-1:0]          ren_tag,
  input  logic                      jmp_we,
  input  logic [DATA_W-1:0]         jmp_pc,
  input  logic [NUM_CDB*CDB_W-1:0]  cdb,
  input  logic                      ckpt_take,
  output logic                      ckpt_ack,
  output logic [CKPT_W-1:0]         ckpt_id,
  output logic                      ckpt_full,
  input  logic                      ckpt_release,
  input  logic [CKPT_W-1:0]         ckpt_rel_id,
  input  logic                      restore,
  input  logic [CKPT_W-1:0]         restore_id,
  input  logic [NUM_CKPT-1:0]       restore_kill,
  input  logic [ADDR_W-1:0]         dbg_addr,
  output logic [ENTRY_W-1:0]        dbg_data
);
  logic [TAG_W-1:0]    tag_q   [NUM_REGS];
  logic [DATA_W-1:0]   val_q   [NUM_REGS];
  logic [TAG_W-1:0]    tag_nxt [NUM_REGS];
  logic [DATA_W-1:0]   val_nxt [NUM_REGS];
  logic [TAG_W-1:0]    snap    [NUM_CKPT][NUM_REGS];
  logic [NUM_CKPT-1:0] free;

  tagged_regfile_ckpt_alloc u_alloc (
    .clk        (clk),
    .rst_n      (rst_n),
    .take       (ckpt_take),
    .rel        (ckpt_release),
    .rel_id     (ckpt_rel_id),
    .restore    (restore),
    .restore_id (restore_id),
    .kill       (restore_kill),
    .ack        (ckpt_ack),
    .id         (ckpt_id),
    .full       (ckpt_full),
    .free       (free)
  );

  // Combinational reads from current state; r0 is never written so it reads zero.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++)
      rd_data[p*ENTRY_W +: ENTRY_W] = {tag_q[rd_addr[p*ADDR_W +: ADDR_W]],
                                       val_q[rd_addr[p*ADDR_W +: ADDR_W]]};
    dbg_data = {tag_q[dbg_addr], val_q[dbg_addr]};
  end

  // Next tag/value per register: restore > rename > jump > CDB wakeup > hold.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      tag_nxt[i] = tag_q[i];
      val_nxt[i] = val_q[i];
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (restore) begin
        tag_nxt[i] = cdb_hit(cdb, snap[restore_id][i]) ? '0 : snap[restore_id][i];
      end else if (ren_we && (ren_addr == ADDR_W'(i))) begin
        tag_nxt[i] = ren_tag;
      end else if (jmp_we && (ren_addr == ADDR_W'(i))) begin
        tag_nxt[i] = '0;
      end else if (cdb_hit(cdb, tag_q[i])) begin
        tag_nxt[i] = '0;
      end
      // Values follow the current tag even during restore; lowest CDB index wins.
      if (jmp_we && (ren_addr == ADDR_W'(i))) begin
        val_nxt[i] = jmp_pc + DATA_W'(4);
      end else begin
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
          if (cdb[k*CDB_W + CDB_ON_BIT] && (tag_q[i] != '0) &&
              (cdb[k*CDB_W + CDB_TAG_LSB +: TAG_W] == tag_q[i]))
            val_nxt[i] = cdb[k*CDB_W + CDB_DATA_LSB +: DATA_W];
        end
      end
    end
  end

  // Architectural state update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_q[i] <= tag_nxt[i];
        val_q[i] <= val_nxt[i];
      end
    end
  end

  // Snapshot arrays: capture next-state tags on grant, otherwise keep live slots woken by the CDB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_CKPT; s++)
        for (int i = 0; i < NUM_REGS; i++)
          snap[s][i] <= '0;
    end else begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (ckpt_ack && (ckpt_id == CKPT_W'(s)))
            snap[s][i] <= tag_nxt[i];
          else if (!free[s] && cdb_hit(cdb, snap[s][i]))
            snap[s][i] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_tagged_regfile_ckpt.sv
// Directed self-checking bench for tagged_regfile_ckpt.
module tb_tagged_regfile_ckpt;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [79:0] rd_data;
  logic        ren_we;
  logic [4:0]  ren_addr;
  logic [7:0]  ren_tag;
  logic        jmp_we;
  logic [31:0] jmp_pc;
  logic [81:0] cdb;
  logic        ckpt_take;
  logic        ckpt_ack;
  logic [1:0]  ckpt_id;
  logic        ckpt_full;
  logic        ckpt_release;
  logic [1:0]  ckpt_rel_id;
  logic        restore;
  logic [1:0]  restore_id;
  logic [3:0]  restore_kill;
  logic [4:0]  dbg_addr;
  logic [39:0] dbg_data;

  int total = 0;
  int bad   = 0;

  tagged_regfile_ckpt dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .ren_we       (ren_we),
    .ren_addr     (ren_addr),
    .ren_tag      (ren_tag),
    .jmp_we       (jmp_we),
    .jmp_pc       (jmp_pc),
    .cdb          (cdb),
    .ckpt_take    (ckpt_take),
    .ckpt_ack     (ckpt_ack),
    .ckpt_id      (ckpt_id),
    .ckpt_full    (ckpt_full),
    .ckpt_release (ckpt_release),
    .ckpt_rel_id  (ckpt_rel_id),
    .restore      (restore),
    .restore_id   (restore_id),
    .restore_kill (restore_kill),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cdb(input int k, input logic on, input logic [7:0] tag, input logic [31:0] data);
    cdb[k*41 +: 41] = {on, tag, data};
  endtask

  function automatic logic [39:0] rdp(input int p);
    return rd_data[p*40 +: 40];
  endfunction

  // Checker
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; ren_we = 1'b0; ren_addr = '0; ren_tag = '0;
    jmp_we = 1'b0; jmp_pc = '0; cdb = '0; ckpt_take = 1'b0; ckpt_release = 1'b0;
    ckpt_rel_id = '0; restore = 1'b0; restore_id = '0; restore_kill = '0; dbg_addr = '0;
    repeat (2) step();

    // Reset state
    rd_addr = {5'd5, 5'd0};
    #1;
    chk("reset_r0", rdp(0), 64'h0);
    chk("reset_r5", rdp(1), 64'h0);
    chk("reset_full", ckpt_full, 64'h0);
    chk("reset_ack", ckpt_ack, 64'h0);
    rst_n = 1'b1;

    // Rename r5 then wake it via CDB0
    ren_we = 1'b1; ren_addr = 5'd5; ren_tag = 8'h12;
    step();
    ren_we = 1'b0;
    rd_addr = {5'd5, 5'd5};
    #1;
    chk("ren_r5", rdp(0), {8'h12, 32'h0});
    set_cdb(0, 1'b1, 8'h12, 32'hDEAD);
    step();
    cdb = '0;
    #1;
    chk("cdb_r5_p0", rdp(0), {8'h00, 32'h0000DEAD});
    chk("cdb_r5_p1", rdp(1), {8'h00, 32'h0000DEAD});

    // Rename r7 in the same cycle its old producer broadcasts
    ren_we = 1'b1; ren_addr = 5'd7; ren_tag = 8'h20;
    step();
    set_cdb(1, 1'b1, 8'h20, 32'hBEEF);
    step();
    ren_we = 1'b0; cdb = '0;
    rd_addr = {5'd7, 5'd5};
    #1;
    chk("ren_cdb_r7", rdp(1), {8'h20, 32'h0000BEEF});

    // Checkpoint around a rename of r3
    ren_we = 1'b1; ren_addr = 5'd3; ren_tag = 8'h05; ckpt_take = 1'b1;
    #1;
    chk("take0_ack", ckpt_ack, 64'h1);
    chk("take0_id", ckpt_id, 64'h0);
    step();
    ckpt_take = 1'b0; ren_tag = 8'h09;
    step();
    ren_we = 1'b0;
    rd_addr = {5'd7, 5'd3};
    #1;
    chk("r3_ren2", rdp(0), {8'h09, 32'h0});
    set_cdb(0, 1'b1, 8'h05, 32'h55);
    step();
    cdb = '0;
    #1;
    chk("r3_stale_cdb", rdp(0), {8'h09, 32'h0});
    // Restore slot 0 while r7's producer completes; a take now is refused
    restore = 1'b1; restore_id = 2'd0; ckpt_take = 1'b1;
    set_cdb(1, 1'b1, 8'h20, 32'h777);
    #1;
    chk("take_during_restore", ckpt_ack, 64'h0);
    step();
    restore = 1'b0; ckpt_take = 1'b0; cdb = '0;
    #1;
    chk("restore_r3", rdp(0), {8'h00, 32'h0});
    chk("restore_r7_cdb", rdp(1), {8'h00, 32'h00000777});
    chk("restore_freed", ckpt_full, 64'h0);

    // Fill all four slots
    for (int k = 0; k < 4; k++) begin
      ckpt_take = 1'b1;
      #1;
      chk($sformatf("fill_ack_%0d", k), ckpt_ack, 64'h1);
      chk($sformatf("fill_id_%0d", k), ckpt_id, 64'(k));
      step();
    end
    ckpt_take = 1'b0;
    #1;
    chk("full_after_4", ckpt_full, 64'h1);
    ckpt_take = 1'b1;
    #1;
    chk("fifth_take_ack", ckpt_ack, 64'h0);
    // Release 2 and take together: released slot not reusable this cycle
    ckpt_release = 1'b1; ckpt_rel_id = 2'd2;
    #1;
    chk("rel_take_same_cycle", ckpt_ack, 64'h0);
    step();
    ckpt_release = 1'b0;
    #1;
    chk("full_after_release", ckpt_full, 64'h0);
    chk("take_after_rel_ack", ckpt_ack, 64'h1);
    chk("take_after_rel_id", ckpt_id, 64'h2);
    step();
    ckpt_take = 1'b0;
    #1;
    chk("full_again", ckpt_full, 64'h1);

    // Restore slot 1 and kill slot 3
    restore = 1'b1; restore_id = 2'd1; restore_kill = 4'b1000;
    step();
    restore = 1'b0; restore_kill = '0;
    #1;
    chk("kill_not_full", ckpt_full, 64'h0);
    chk("restore1_r7", rdp(1), {8'h00, 32'h00000777});
    ckpt_take = 1'b1;
    #1;
    chk("kill_take_id1", ckpt_id, 64'h1);
    step();
    #1;
    chk("kill_take_ack3", ckpt_ack, 64'h1);
    chk("kill_take_id3", ckpt_id, 64'h3);
    step();
    ckpt_take = 1'b0;
    #1;
    chk("kill_full", ckpt_full, 64'h1);

    // r0 ignores renames
    ren_we = 1'b1; ren_addr = 5'd0; ren_tag = 8'h33;
    step();
    ren_we = 1'b0;
    rd_addr = {5'd7, 5'd0};
    #1;
    chk("r0_zero", rdp(0), 64'h0);

    // Jump link write-back
    jmp_we = 1'b1; ren_addr = 5'd1; jmp_pc = 32'h100;
    step();
    jmp_we = 1'b0;
    dbg_addr = 5'd1;
    #1;
    chk("jmp_r1", dbg_data, {8'h00, 32'h00000104});
    ren_we = 1'b1; ren_addr = 5'd1; ren_tag = 8'h40;
    step();
    ren_we = 1'b0;
    #1;
    chk("ren_r1", dbg_data, {8'h40, 32'h00000104});
    jmp_we = 1'b1; jmp_pc = 32'h200;
    step();
    jmp_we = 1'b0;
    #1;
    chk("jmp_clears_tag", dbg_data, {8'h00, 32'h00000204});

    // Reset during restore overrides everything
    rst_n = 1'b0; restore = 1'b1; restore_id = 2'd0; ckpt_take = 1'b1;
    step();
    restore = 1'b0;
    #1;
    chk("rst_ack_gated", ckpt_ack, 64'h0);
    chk("rst_r1", dbg_data, 64'h0);
    chk("rst_r7", rdp(1), 64'h0);
    chk("rst_full", ckpt_full, 64'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ack", ckpt_ack, 64'h1);
    chk("post_rst_id", ckpt_id, 64'h0);
    step();
    ckpt_take = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
